// File: rtl/ce_rate_scheduler_if.sv
// ---------------------------------------------------------------------------
// ce_rate_scheduler_if
// Configuration write channel for the clock-enable scheduler.
//   cfg_valid   : software requests a period/phase write
//   cfg_ready   : scheduler can accept the write this cycle
//   cfg_ch      : target channel index
//   cfg_period  : new period in sysce cycles
//   cfg_phase   : start phase (used only when the scheduler starts)
// master = software side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface ce_rate_scheduler_if #(
  parameter int CNT_WIDTH = 16,
  parameter int CH_W      = 2
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/ce_rate_scheduler.sv
// ---------------------------------------------------------------------------
// ce_rate_scheduler
// Runtime-programmable multi-rate clock-enable generator. Each of NUM_CH
// channels has its own period and start phase; period updates written while
// running are held in a shadow register and applied only at that channel's
// wrap, so a strobe is never shortened or doubled. A STOP/LOAD/RUN/DRAIN
// state machine starts all channels phase-aligned and lets channel 0 finish
// its current period before stopping.
//
// Ports:
//   sysclk, sysclr_n : clock, asynchronous active-low reset
//   sysce            : global enable; counters advance only when high
//   run              : 1 = start/keep running, 0 = request stop
//   err_clr          : clears cfg_err (a coincident new error wins)
//   cfg (slave)      : configuration write channel (valid/ready)
//   ce               : registered one-cycle strobe per channel
//   ce_logic         : duplicate of ce from its own flops (optional)
//   sync_pulse       : every channel strobes in the same cycle
//   busy             : scheduler is not stopped
//   cfg_err          : sticky flag for a rejected configuration write
//
// Optional feature: define CE_SCHED_LOGIC_EN to add the ce_logic port.
// ---------------------------------------------------------------------------
module ce_rate_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int CH_W      = 2
) (
  input  logic               sysclk,
  input  logic               sysclr_n,
  input  logic               sysce,
  input  logic               run,
  input  logic               err_clr,
  ce_rate_scheduler_if.slave cfg,
`ifdef CE_SCHED_LOGIC_EN
  output logic [NUM_CH-1:0]  ce_logic,
`endif
  output logic [NUM_CH-1:0]  ce,
  output logic               sync_pulse,
  output logic               busy,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_WIDTH-1:0] shadow_period [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow_phase  [NUM_CH];
  logic [CNT_WIDTH-1:0] period        [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt           [NUM_CH];
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    ch_hit;
  logic [NUM_CH-1:0]    wrap;
  logic                 sel_pending;
  logic                 loading;
  logic                 counting;
  logic                 cfg_acc;
  logic                 cfg_bad;
  logic                 wr_ok;
  logic                 wr_err;

  // Channel decode of the write target; an out-of-range cfg_ch hits nothing.
  always_comb begin
    ch_hit      = {NUM_CH{1'b0}};
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i]   = (cfg.cfg_ch == CH_W'(i));
      sel_pending = sel_pending | (ch_hit[i] & pending[i]);
    end
  end

  // FSM output decode: load strobe, counting enable and write readiness.
  always_comb begin
    loading       = 1'b0;
    counting      = 1'b0;
    cfg.cfg_ready = 1'b1;
    case (state)
      ST_STOP: begin
        cfg.cfg_ready = 1'b1;
      end
      ST_LOAD: begin
        loading       = 1'b1;
        cfg.cfg_ready = ~sel_pending;
      end
      ST_RUN, ST_DRAIN: begin
        counting      = sysce;
        cfg.cfg_ready = ~sel_pending;
      end
      default: begin
        cfg.cfg_ready = 1'b1;
      end
    endcase
  end

  // Per-channel wrap detection; only meaningful on a counting cycle.
  always_comb begin
    wrap = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = counting & (cnt[i] == (period[i] - CNT_WIDTH'(1)));
    end
  end

  // Write classification: bad writes are still accepted but only flag cfg_err.
  always_comb begin
    cfg_acc = cfg.cfg_valid & cfg.cfg_ready;
    cfg_bad = (cfg.cfg_period == {CNT_WIDTH{1'b0}}) | (cfg.cfg_phase >= cfg.cfg_period);
    wr_ok   = cfg_acc & ~cfg_bad;
    wr_err  = cfg_acc & cfg_bad & (|ch_hit);
  end

  // FSM next-state logic; run wins over channel 0's wrap in DRAIN.
  always_comb begin
    next_state = state;
    case (state)
      ST_STOP: begin
        if (run) next_state = ST_LOAD;
        else     next_state = ST_STOP;
      end
      ST_LOAD: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!run) next_state = ST_DRAIN;
        else      next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (run)          next_state = ST_RUN;
        else if (wrap[0]) next_state = ST_STOP;
        else              next_state = ST_DRAIN;
      end
      default: begin
        next_state = ST_STOP;
      end
    endcase
  end

  // FSM state register plus registered busy flag.
  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      state <= ST_STOP;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != ST_STOP);
    end
  end

  // Per-channel counters, active/shadow period, phase and pending update.
  // A write needs cfg_ready, so it can never coincide with a pending clear
  // on the same channel; a write in the wrap cycle lands at the next wrap.
  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_period[i] <= CNT_WIDTH'(1);
        shadow_phase[i]  <= {CNT_WIDTH{1'b0}};
        period[i]        <= CNT_WIDTH'(1);
        cnt[i]           <= {CNT_WIDTH{1'b0}};
      end
      pending <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (loading) begin
          period[i]  <= shadow_period[i];
          cnt[i]     <= shadow_phase[i];
          pending[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i] <= {CNT_WIDTH{1'b0}};
          if (pending[i]) begin
            period[i]  <= shadow_period[i];
            pending[i] <= 1'b0;
          end
        end else if (counting) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end else if (state == ST_STOP) begin
          cnt[i] <= {CNT_WIDTH{1'b0}};
        end
        if (wr_ok && ch_hit[i]) begin
          shadow_period[i] <= cfg.cfg_period;
          shadow_phase[i]  <= cfg.cfg_phase;
          if ((state == ST_RUN) || (state == ST_DRAIN)) begin
            pending[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Registered strobes, sync pulse and sticky error (set beats clear).
  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      ce         <= {NUM_CH{1'b0}};
      sync_pulse <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      ce         <= wrap;
      sync_pulse <= &wrap;
      if (wr_err)       cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
    end
  end

`ifdef CE_SCHED_LOGIC_EN
  // Separate strobe flops for control-logic fan-out, bit-identical to ce.
  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      ce_logic <= {NUM_CH{1'b0}};
    end else begin
      ce_logic <= wrap;
    end
  end
`endif

endmodule

// File: tb/tb_ce_rate_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ce_rate_scheduler
// Self-checking bench for ce_rate_scheduler. A behavioural model tracks, per
// channel, the number of sysce ticks remaining until the next strobe and
// predicts every output each cycle; directed scenarios add absolute checks.
// ---------------------------------------------------------------------------
module tb_ce_rate_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic           sysclk   = 1'b0;
  logic           sysclr_n = 1'b0;
  logic           sysce    = 1'b0;
  logic           run      = 1'b0;
  logic           err_clr  = 1'b0;
  logic [NCH-1:0] ce;
  logic           sync_pulse;
  logic           busy;
  logic           cfg_err;
`ifdef CE_SCHED_LOGIC_EN
  logic [NCH-1:0] ce_logic;
`endif

  ce_rate_scheduler_if #(.CNT_WIDTH(CW), .CH_W(CHW)) cfg_if();

  ce_rate_scheduler #(.NUM_CH(NCH), .CNT_WIDTH(CW), .CH_W(CHW)) dut (
    .sysclk     (sysclk),
    .sysclr_n   (sysclr_n),
    .sysce      (sysce),
    .run        (run),
    .err_clr    (err_clr),
    .cfg        (cfg_if),
`ifdef CE_SCHED_LOGIC_EN
    .ce_logic   (ce_logic),
`endif
    .ce         (ce),
    .sync_pulse (sync_pulse),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 sysclk = ~sysclk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 stopped, 1 loading, 2 running, 3 draining
  int             m_mode;
  int             m_per    [NCH];
  int             m_sh_per [NCH];
  int             m_sh_ph  [NCH];
  int             m_rem    [NCH];   // sysce ticks left until this channel's strobe tick
  bit             m_pend   [NCH];
  logic [NCH-1:0] exp_ce;
  logic           exp_sync;
  logic           exp_busy;
  logic           exp_err;

  function automatic void model_reset();
    m_mode = 0;
    for (int i = 0; i < NCH; i++) begin
      m_per[i] = 1; m_sh_per[i] = 1; m_sh_ph[i] = 0; m_rem[i] = 1; m_pend[i] = 1'b0;
    end
    exp_ce = '0; exp_sync = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
  endfunction

  function automatic bit model_ready();
    return (m_mode == 0) || !m_pend[int'(cfg_if.cfg_ch)];
  endfunction

  function automatic void model_step();
    bit             acc, bad, tick;
    logic [NCH-1:0] fire;
    int             nmode;
    int             ch;
    ch   = int'(cfg_if.cfg_ch);
    acc  = cfg_if.cfg_valid && model_ready();
    bad  = (cfg_if.cfg_period == 0) || (cfg_if.cfg_phase >= cfg_if.cfg_period);
    tick = (m_mode >= 2) && sysce;
    for (int i = 0; i < NCH; i++) fire[i] = tick && (m_rem[i] == 1);
    case (m_mode)
      0: nmode = run ? 1 : 0;
      1: nmode = 2;
      2: nmode = run ? 2 : 3;
      default: nmode = run ? 2 : (fire[0] ? 0 : 3);
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (m_mode == 1) begin
        m_per[i]  = m_sh_per[i];
        m_rem[i]  = m_sh_per[i] - m_sh_ph[i];
        m_pend[i] = 1'b0;
      end else if (tick) begin
        if (fire[i]) begin
          if (m_pend[i]) begin
            m_per[i]  = m_sh_per[i];
            m_pend[i] = 1'b0;
          end
          m_rem[i] = m_per[i];
        end else begin
          m_rem[i] = m_rem[i] - 1;
        end
      end
    end
    if (acc && ch < NCH) begin
      if (bad) begin
        exp_err = 1'b1;
      end else begin
        m_sh_per[ch] = int'(cfg_if.cfg_period);
        m_sh_ph[ch]  = int'(cfg_if.cfg_phase);
        if (m_mode >= 2) m_pend[ch] = 1'b1;
      end
    end else if (err_clr) begin
      exp_err = 1'b0;
    end
    if (acc && ch < NCH && bad) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
    exp_ce   = fire;
    exp_sync = &fire;
    exp_busy = (nmode != 0);
    m_mode   = nmode;
  endfunction

  task automatic check_outputs();
    check_eq("ce", 32'(ce), 32'(exp_ce));
    check_eq("sync_pulse", 32'(sync_pulse), 32'(exp_sync));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("cfg_err", 32'(cfg_err), 32'(exp_err));
    check_eq("cfg_ready", 32'(cfg_if.cfg_ready), 32'(model_ready()));
`ifdef CE_SCHED_LOGIC_EN
    check_eq("ce_logic", 32'(ce_logic), 32'(exp_ce));
`endif
  endtask

  // One clock: check at the falling edge, advance the model, return #1 after the rising edge.
  task automatic cycle();
    @(negedge sysclk);
    check_outputs();
    model_step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int per, input int ph);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CHW'(ch);
    cfg_if.cfg_period = CW'(per);
    cfg_if.cfg_phase  = CW'(ph);
    cycle();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  initial begin
    int n_ce0, n_ce3, n_sync, first, n_ce1;
    int pos [$];
    logic [5:0] pat;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_phase  = '0;
    model_reset();

    // reset state
    #2;
    check_outputs();
    @(posedge sysclk); #1;
    sysclr_n = 1'b1;
    sysce    = 1'b1;

    // basic rates: periods 1..4, phase 0
    for (int c = 0; c < NCH; c++) cfg_write(c, c + 1, 0);
    run = 1'b1; n_ce0 = 0; n_ce3 = 0; n_sync = 0;
    for (int k = 1; k <= 27; k++) begin
      n_ce0  += int'(ce[0]);
      n_ce3  += int'(ce[3]);
      n_sync += int'(sync_pulse);
      cycle();
    end
    check_eq("basic_ce0_count", 32'(n_ce0), 32'd24);
    check_eq("basic_ce3_count", 32'(n_ce3), 32'd6);
    check_eq("basic_sync_count", 32'(n_sync), 32'd2);
    run = 1'b0;
    repeat (4) cycle();

    // phase: ch1 period 4 phase 3 strobes one sysce cycle after LOAD
    cfg_write(1, 4, 3);
    run = 1'b1; first = -1; n_ce1 = 0;
    for (int k = 1; k <= 12; k++) begin
      if (ce[1] && first < 0) first = k;
      n_ce1 += int'(ce[1]);
      cycle();
    end
    check_eq("phase_first_strobe", 32'(first), 32'd4);
    check_eq("phase_strobe_count", 32'(n_ce1), 32'd3);
    run = 1'b0;
    repeat (4) cycle();

    // runtime update: ch0 period 5, rewrite to 2 mid-count
    cfg_write(0, 5, 0);
    run = 1'b1;
    repeat (5) cycle();
    cfg_write(0, 2, 0);
    cfg_if.cfg_ch = '0;
    check_eq("upd_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    cycle();
    check_eq("upd_ready_high", 32'(cfg_if.cfg_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      pat[k] = ce[0];
      cycle();
    end
    check_eq("upd_ce0_pattern", 32'(pat), 32'h15);
    run = 1'b0;
    repeat (5) cycle();

    // gating: sysce alternating with ch0 at period 2
    run = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (ce[0]) pos.push_back(k);
      sysce = (k % 2 == 0);
      cycle();
    end
    if (pos.size() >= 3) begin
      check_eq("gate_gap1", 32'(pos[1] - pos[0]), 32'd4);
      check_eq("gate_gap2", 32'(pos[2] - pos[1]), 32'd4);
    end else begin
      check_eq("gate_strobes_seen", 32'(pos.size()), 32'd3);
    end
    sysce = 1'b1; run = 1'b0;
    repeat (5) cycle();

    // errors: zero period and phase >= period
    cfg_write(2, 0, 0);
    cfg_write(2, 5, 5);
    check_eq("err_set", 32'(cfg_err), 32'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check_eq("err_cleared", 32'(cfg_err), 32'd0);

    // stop: ch0 period 8, drop run at cnt=2
    cfg_write(0, 8, 0);
    run = 1'b1;
    repeat (4) cycle();
    run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check_eq("stop_busy_drain", 32'(busy), 32'd1);
      cycle();
    end
    check_eq("stop_busy_low", 32'(busy), 32'd0);
    check_eq("stop_final_ce0", 32'(ce[0]), 32'd1);
    cycle();

    // reset mid-run clears everything, including programming
    run = 1'b1;
    repeat (4) cycle();
    cfg_write(3, 0, 0);
    repeat (3) cycle();
    check_eq("pre_rst_err", 32'(cfg_err), 32'd1);
    sysclr_n = 1'b0;
    #1;
    check_eq("rst_ce", 32'(ce), 32'd0);
    check_eq("rst_sync", 32'(sync_pulse), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(cfg_err), 32'd0);
    model_reset();
    @(posedge sysclk); #1;
    sysclr_n = 1'b1;
    repeat (6) cycle();
    check_eq("rst_period1_ce", 32'(ce), 32'hF);
    check_eq("rst_period1_sync", 32'(sync_pulse), 32'd1);

    // randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      sysce             = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      err_clr           = ($urandom_range(0, 15) == 0);
      cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_ch     = CHW'($urandom_range(0, 3));
      cfg_if.cfg_period = CW'($urandom_range(0, 6));
      cfg_if.cfg_phase  = CW'($urandom_range(0, 5));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
